pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller for the multi-stage CPU core. It replaces the fixed stall-request combiner.
- Merges per-stage stall and flush requests into per-stage freeze, bubble and flush controls.
- Owns a registered IO-wait state machine that holds the pipeline until the user confirms with the enter button, with an optional timeout.
- Sits between the pipeline stages (IF=0 … WB=NUM_STAGES-1) and the pipeline registers.

Parameters:
NUM_STAGES, 5, number of pipeline stages; stage 0 = PC/IF, highest = WB.
IO_STAGE, 3, stage index whose io_req triggers the IO-wait FSM; must be < NUM_STAGES.
IO_TIMEOUT, 0, cycles to wait for enter before forced release; 0 = wait forever.
CNT_W, 32, width of the timeout counter and the perf counters.

Ports:
clock  in  1  core clock.
reset  in  1  reset, synchronous, active-high.
stall_req  in  NUM_STAGES  per-stage stall request (e.g. load-use from ID).
flush_req  in  NUM_STAGES  per-stage flush request (branch/jump resolved in that stage).
io_req  in  1  IO access in IO_STAGE needs user confirmation; level, held until serviced.
enter  in  1  debounced enter button, level.
stall  out  NUM_STAGES  freeze stage i (hold its pipeline register and, for i=0, the PC).
bubble  out  NUM_STAGES  insert NOP into stage i's input register; bit 0 always 0.
flush  out  NUM_STAGES  clear stage i's output register.
io_wait  out  1  FSM in WAIT state.
io_ack  out  1  one-cycle pulse: IO access may complete.
io_timeout  out  1  one-cycle pulse, coincident with io_ack, when release was by timeout.
stall_cycles  out  CNT_W  perf counter (see Optional Feature).
flush_events  out  CNT_W  perf counter (see Optional Feature).

Behaviour:
- IO FSM states, registered:
  - IDLE → WAIT when io_req=1.
  - WAIT → ACK on an enter rising edge. Edge detection uses an internal enter_q register, so a held button produces one edge.
  - WAIT → ACK also when IO_TIMEOUT>0 and the wait counter reaches IO_TIMEOUT-1; io_timeout is pulsed in this case.
  - ACK → HOLD unconditionally; io_ack=1 during ACK only.
  - HOLD → IDLE when io_req=0. This prevents a still-asserted io_req from re-arming in the same access.
- Wait counter:
  - Cleared on entering WAIT; increments each WAIT cycle.
  - An enter edge and a timeout in the same cycle count as enter (io_timeout=0).
- Effective stall vector: req_eff = stall_req, with bit IO_STAGE also ORed with (state==WAIT or state==ACK).
- Freeze/bubble:
  - k = highest index with req_eff=1.
  - stall[i]=1 for all i<=k.
  - bubble[k+1]=1 if k+1<NUM_STAGES.
  - If no request: stall=0, bubble=0.
- Flush:
  - A flush_req[j] is honoured only if j>k; requests from frozen stages are ignored and must be re-asserted by the stage.
  - j = highest honoured requester; flush[i]=1 for all i<j.
  - stall[i] and bubble[i] are forced 0 for i<j, so the redirect proceeds.
  - flush_req[0] has no effect.
- stall, bubble and flush are combinational from the inputs and registered state (zero-cycle latency). The FSM and counters update on posedge clock.
- Reset: state=IDLE, enter_q=0, wait counter=0, counters=0, io_ack=0, io_timeout=0, io_wait=0. stall, bubble and flush follow their inputs with FSM bits clear.
- Reset during WAIT or ACK: the FSM returns to IDLE next edge and no io_ack is emitted.
- enter edges in IDLE or HOLD are ignored.

Optional Feature:
HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle with stall[0]=1.
  - flush_events increments every cycle with any flush bit=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
All scenarios use NUM_STAGES=5, IO_STAGE=3, IO_TIMEOUT=0 unless stated.
1. stall_req=5'b00010 → stall=5'b00011, bubble=5'b00100, flush=0.
2. flush_req=5'b00100, no stalls → flush=5'b00011, stall=0. Add stall_req=5'b01000 → flush ignored: flush=0, stall=5'b01111, bubble=5'b10000.
3. io_req=1 → next cycle io_wait=1, stall=5'b01111. Hold enter high 3 cycles → exactly one io_ack pulse. Keep io_req=1 → FSM stays in HOLD, no second WAIT. Drop io_req → IDLE.
4. IO_TIMEOUT=4, io_req=1, no enter → io_ack and io_timeout both pulse exactly 4 cycles after io_wait rises.
5. Assert reset for 1 cycle while in WAIT → io_wait=0 next cycle, no io_ack. A later enter edge with io_req=0 → no io_ack.
6. With HAZ_PERF_CNT_EN: 7 cycles with stall[0]=1 and 2 flush cycles → stall_cycles=7, flush_events=2. Without the macro, both ports read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: request/control bundle between pipeline stages and the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32
);
    logic [NUM_STAGES-1:0] stall_req, flush_req, stall, bubble, flush;
    logic                  io_req, enter, io_wait, io_ack, io_timeout;
    logic [CNT_W-1:0]      stall_cycles, flush_events;
    modport master (
        output stall_req, flush_req, io_req, enter,
        input  stall, bubble, flush, io_wait, io_ack, io_timeout, stall_cycles, flush_events
    );
    modport slave (
        input  stall_req, flush_req, io_req, enter,
        output stall, bubble, flush, io_wait, io_ack, io_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: merges stage stall/flush requests and runs the IO-wait FSM.
// Perf counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int IO_STAGE   = 3,
    parameter int IO_TIMEOUT = 0,
    parameter int CNT_W      = 32
) (
    input logic               clock,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;
    state_t                state;
    logic                  enter_q, io_ack_q, io_timeout_q, io_wait_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic [NUM_STAGES-1:0] req_eff, stall_v, bubble_v, flush_v;
    logic                  enter_edge, timeout_hit;
    int                    k, j;

    assign enter_edge  = bus.enter && !enter_q;
    assign timeout_hit = (IO_TIMEOUT > 0) && (wait_cnt == CNT_W'(IO_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            enter_q      <= 1'b0;
            wait_cnt     <= '0;
            io_ack_q     <= 1'b0;
            io_timeout_q <= 1'b0;
            io_wait_q    <= 1'b0;
        end else begin
            enter_q      <= bus.enter;
            io_ack_q     <= 1'b0;
            io_timeout_q <= 1'b0;
            case (state)
                IDLE: if (bus.io_req) begin
                    state     <= WAIT;
                    wait_cnt  <= '0;
                    io_wait_q <= 1'b1;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // enter wins over a simultaneous timeout
                    if (enter_edge || timeout_hit) begin
                        state        <= ACK;
                        io_wait_q    <= 1'b0;
                        io_ack_q     <= 1'b1;
                        io_timeout_q <= !enter_edge;
                    end
                end
                ACK:     state <= HOLD;
                HOLD:    state <= bus.io_req ? HOLD : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_eff           = bus.stall_req;
        req_eff[IO_STAGE] = bus.stall_req[IO_STAGE] || state == WAIT || state == ACK;
        k = -1;
        for (int i = 0; i < NUM_STAGES; i++) if (req_eff[i]) k = i;
        // frozen stages cannot redirect; stage 0 never flushes anything
        j = 0;
        for (int i = 1; i < NUM_STAGES; i++) if (bus.flush_req[i] && i > k) j = i;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stall_v[i]  = i <= k && i >= j;
            bubble_v[i] = k >= 0 && i == k + 1 && i >= j;
            flush_v[i]  = i < j;
        end
    end

    assign bus.stall      = stall_v;
    assign bus.bubble     = bubble_v;
    assign bus.flush      = flush_v;
    assign bus.io_wait    = io_wait_q;
    assign bus.io_ack     = io_ack_q;
    assign bus.io_timeout = io_timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_v[0] && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if ((|flush_v) && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of freeze/flush merging, IO-wait FSM and perf counters.
module tb_pipe_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    pipe_hazard_ctrl_if #(.NUM_STAGES(5), .CNT_W(32)) b1 ();
    pipe_hazard_ctrl_if #(.NUM_STAGES(5), .CNT_W(32)) b2 ();

    pipe_hazard_ctrl #(.NUM_STAGES(5), .IO_STAGE(3), .IO_TIMEOUT(0), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .bus(b1)
    );
    pipe_hazard_ctrl #(.NUM_STAGES(5), .IO_STAGE(3), .IO_TIMEOUT(4), .CNT_W(32)) dut_to (
        .clock(clock), .reset(reset), .bus(b2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        b1.stall_req = '0; b1.flush_req = '0; b1.io_req = 0; b1.enter = 0;
        b2.stall_req = '0; b2.flush_req = '0; b2.io_req = 0; b2.enter = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        total++;
        if ({b1.io_wait, b1.io_ack, b1.io_timeout} !== 3'b000)
            $display("FAIL reset_fsm: got %b expected 000", {b1.io_wait, b1.io_ack, b1.io_timeout});
        else passed++;
        total++;
        if ({b1.stall, b1.bubble, b1.flush} !== 15'd0)
            $display("FAIL reset_ctrl: got %b expected 0", {b1.stall, b1.bubble, b1.flush});
        else passed++;
        total++;
        if ({b1.stall_cycles, b1.flush_events} !== 64'd0)
            $display("FAIL reset_cnt: got %h expected 0", {b1.stall_cycles, b1.flush_events});
        else passed++;
    endtask

    task automatic test_freeze_flush();
        logic [4:0]  sr [9] = '{5'b00010, 5'b00000, 5'b01000, 5'b10000, 5'b00000, 5'b00000, 5'b00010, 5'b00001, 5'b00001};
        logic [4:0]  fr [9] = '{5'b00000, 5'b00100, 5'b00100, 5'b00000, 5'b10100, 5'b00001, 5'b01000, 5'b00100, 5'b00010};
        logic [14:0] ex [9] = '{{5'b00011, 5'b00100, 5'b00000},
                                {5'b00000, 5'b00000, 5'b00011},
                                {5'b01111, 5'b10000, 5'b00000},
                                {5'b11111, 5'b00000, 5'b00000},
                                {5'b00000, 5'b00000, 5'b01111},
                                {5'b00000, 5'b00000, 5'b00000},
                                {5'b00000, 5'b00000, 5'b00111},
                                {5'b00000, 5'b00000, 5'b00011},
                                {5'b00000, 5'b00010, 5'b00001}};
        for (int i = 0; i < 9; i++) begin
            b1.stall_req = sr[i];
            b1.flush_req = fr[i];
            #1;
            total++;
            if ({b1.stall, b1.bubble, b1.flush} !== ex[i])
                $display("FAIL comb_%0d: stall/bubble/flush got %b expected %b", i, {b1.stall, b1.bubble, b1.flush}, ex[i]);
            else passed++;
        end
        b1.stall_req = '0;
        b1.flush_req = '0;
        tick();
    endtask

    task automatic test_io_enter();
        int acks = 0;
        int tos = 0;
        b1.io_req = 1;
        tick();
        total++;
        if (b1.io_wait !== 1'b1) $display("FAIL io_wait_rise: got %b expected 1", b1.io_wait);
        else passed++;
        total++;
        if ({b1.stall, b1.bubble} !== {5'b01111, 5'b10000})
            $display("FAIL io_stall: got %b expected 0111110000", {b1.stall, b1.bubble});
        else passed++;
        b1.flush_req = 5'b00100;
        #1;
        total++;
        if (b1.flush !== 5'b00000) $display("FAIL io_flush_blocked: got %b expected 00000", b1.flush);
        else passed++;
        b1.flush_req = '0;
        b1.enter = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            acks += int'(b1.io_ack);
            tos += int'(b1.io_timeout);
        end
        total++;
        if (acks !== 1) $display("FAIL io_ack_count: got %0d expected 1", acks);
        else passed++;
        total++;
        if (tos !== 0) $display("FAIL io_enter_timeout: got %0d expected 0", tos);
        else passed++;
        b1.enter = 0;
        tick();
        b1.enter = 1;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            acks += int'(b1.io_ack) + int'(b1.io_wait);
        end
        total++;
        if (acks !== 0) $display("FAIL io_hold_rearm: got %0d expected 0", acks);
        else passed++;
        total++;
        if (b1.stall !== 5'b00000) $display("FAIL io_hold_stall: got %b expected 00000", b1.stall);
        else passed++;
        b1.enter = 0;
        b1.io_req = 0;
        tick();
        b1.io_req = 1;
        tick();
        total++;
        if (b1.io_wait !== 1'b1) $display("FAIL io_rearm_after_idle: got %b expected 1", b1.io_wait);
        else passed++;
        b1.enter = 1;
        tick();
        b1.enter = 0;
        b1.io_req = 0;
        tick(); tick();
    endtask

    task automatic test_io_timeout();
        int ack_at = -1;
        logic to_at = 1'b0;
        b2.io_req = 1;
        tick();
        total++;
        if (b2.io_wait !== 1'b1) $display("FAIL to_wait_rise: got %b expected 1", b2.io_wait);
        else passed++;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (b2.io_ack && ack_at < 0) begin
                ack_at = c;
                to_at = b2.io_timeout;
            end
        end
        total++;
        if (ack_at !== 4) $display("FAIL to_ack_delay: got %0d expected 4", ack_at);
        else passed++;
        total++;
        if (to_at !== 1'b1) $display("FAIL to_pulse: got %b expected 1", to_at);
        else passed++;
        b2.io_req = 0;
        tick();
        b2.io_req = 1;
        tick(); tick(); tick(); tick();
        b2.enter = 1;
        tick();
        total++;
        if ({b2.io_ack, b2.io_timeout} !== 2'b10)
            $display("FAIL to_enter_wins: ack/timeout got %b expected 10", {b2.io_ack, b2.io_timeout});
        else passed++;
        b2.enter = 0;
        b2.io_req = 0;
        tick(); tick();
    endtask

    task automatic test_reset_in_wait();
        int acks = 0;
        b1.io_req = 1;
        tick();
        reset = 1;
        b1.io_req = 0;
        tick();
        reset = 0;
        total++;
        if ({b1.io_wait, b1.io_ack} !== 2'b00)
            $display("FAIL rst_wait: wait/ack got %b expected 00", {b1.io_wait, b1.io_ack});
        else passed++;
        tick();
        b1.enter = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            acks += int'(b1.io_ack) + int'(b1.io_wait);
        end
        total++;
        if (acks !== 0) $display("FAIL rst_idle_enter: got %0d expected 0", acks);
        else passed++;
        b1.enter = 0;
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_s, exp_f;
`ifdef HAZ_PERF_CNT_EN
        exp_s = 32'd7;
        exp_f = 32'd2;
`else
        exp_s = 32'd0;
        exp_f = 32'd0;
`endif
        reset = 1;
        tick();
        reset = 0;
        b1.stall_req = 5'b00010;
        repeat (7) tick();
        b1.stall_req = '0;
        b1.flush_req = 5'b00100;
        repeat (2) tick();
        b1.flush_req = '0;
        tick();
        total++;
        if (b1.stall_cycles !== exp_s) $display("FAIL perf_stall: got %0d expected %0d", b1.stall_cycles, exp_s);
        else passed++;
        total++;
        if (b1.flush_events !== exp_f) $display("FAIL perf_flush: got %0d expected %0d", b1.flush_events, exp_f);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_freeze_flush();
        test_io_enter();
        test_io_timeout();
        test_reset_in_wait();
        test_perf();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
